// File: rtl/pipeline_hazard_ctrl.sv
// +-----------------------------------------------------------------------------+
// | pipeline_hazard_ctrl: stall/bubble/flush/redirect control for the F-D-E-M   |
// | pipeline. Optional perf counters are built when HAZARD_PERF_EN is defined.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int REG_AW       = 4,
    parameter int PC_W         = 12,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] srcAddD1,
    input  logic [REG_AW-1:0] srcAddD2,
    input  logic              srcUseD1,
    input  logic              srcUseD2,
    input  logic [REG_AW-1:0] destAddE,
    input  logic              RegWriteE,
    input  logic              MemReadE,
    input  logic              branchTakenE,
    input  logic [PC_W-1:0]   branchTargetE,
    input  logic              memReq,
    input  logic              memReady,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              bubbleE,
    output logic              flushD,
    output logic              pcSelF,
    output logic [PC_W-1:0]   pcTargetF
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]       stallCycles,
    output logic [15:0]       redirectCount
`endif
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    localparam logic [1:0] FLUSH_INIT  = 2'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

    logic [1:0] state;
    logic [1:0] next_state;
    logic [1:0] fcnt;
    logic [1:0] next_fcnt;
    logic       mem_wait;
    logic       load_use;

    assign mem_wait = memReq & ~memReady;

    // Register 0 is not special here: a match on address 0 is a real hazard.
    assign load_use = MemReadE & RegWriteE &
                      ((srcUseD1 & (srcAddD1 == destAddE)) |
                       (srcUseD2 & (srcAddD2 == destAddE)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            fcnt  <= 2'd0;
        end else begin
            state <= next_state;
            fcnt  <= next_fcnt;
        end
    end

    always_comb begin
        next_state = state;
        next_fcnt  = fcnt;
        case (state)
            ST_RUN: begin
                if (mem_wait) begin
                    next_state = ST_MEM_WAIT;
                end else if (branchTakenE && MULTI_FLUSH) begin
                    next_state = ST_REDIRECT;
                    next_fcnt  = FLUSH_INIT;
                end
            end
            ST_MEM_WAIT: begin
                if (memReady) begin
                    next_state = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                // A memory stall freezes the flush countdown.
                if (!mem_wait) begin
                    next_fcnt = fcnt - 2'd1;
                    if (fcnt == 2'd1) begin
                        next_state = ST_RUN;
                    end
                end
            end
            default: begin
                next_state = ST_RUN;
                next_fcnt  = 2'd0;
            end
        endcase
    end

    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        bubbleE   = 1'b0;
        flushD    = 1'b0;
        pcSelF    = 1'b0;
        pcTargetF = '0;
        if (reset) begin
            case (state)
                ST_RUN: begin
                    if (mem_wait) begin
                        {stallF, stallD, stallE, stallM} = 4'hF;
                    end else if (branchTakenE) begin
                        pcSelF    = 1'b1;
                        flushD    = 1'b1;
                        bubbleE   = 1'b1;
                        pcTargetF = branchTargetE;
                    end else if (load_use) begin
                        stallF  = 1'b1;
                        stallD  = 1'b1;
                        bubbleE = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!memReady) begin
                        {stallF, stallD, stallE, stallM} = 4'hF;
                    end
                end
                ST_REDIRECT: begin
                    flushD = 1'b1;
                    if (mem_wait) begin
                        {stallF, stallD, stallE, stallM} = 4'hF;
                    end
                end
                default: begin
                    stallF = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCycles   <= 16'd0;
            redirectCount <= 16'd0;
        end else begin
            if (stallF && (stallCycles != 16'hFFFF)) begin
                stallCycles <= stallCycles + 16'd1;
            end
            if (pcSelF && (redirectCount != 16'hFFFF)) begin
                redirectCount <= redirectCount + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// randomized traffic compared against a behavioural model of the hazard rules.
`default_nettype none

module tb_pipeline_hazard_ctrl;

    localparam int FLUSH = 2;

    logic        clk;
    logic        reset;
    logic [3:0]  srcAddD1;
    logic [3:0]  srcAddD2;
    logic        srcUseD1;
    logic        srcUseD2;
    logic [3:0]  destAddE;
    logic        RegWriteE;
    logic        MemReadE;
    logic        branchTakenE;
    logic [11:0] branchTargetE;
    logic        memReq;
    logic        memReady;
    logic        stallF;
    logic        stallD;
    logic        stallE;
    logic        stallM;
    logic        bubbleE;
    logic        flushD;
    logic        pcSelF;
    logic [11:0] pcTargetF;
`ifdef HAZARD_PERF_EN
    logic [15:0] stallCycles;
    logic [15:0] redirectCount;
`endif

    logic [18:0] obs;
    assign obs = {stallF, stallD, stallE, stallM, bubbleE, flushD, pcSelF, pcTargetF};

    int checks;
    int errors;

    // Model state: waiting on memory, remaining extra flush cycles, perf counts.
    bit m_wait;
    int m_flush;
    int m_stalls;
    int m_redirs;

    pipeline_hazard_ctrl #(
        .REG_AW       (4),
        .PC_W         (12),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .srcAddD1      (srcAddD1),
        .srcAddD2      (srcAddD2),
        .srcUseD1      (srcUseD1),
        .srcUseD2      (srcUseD2),
        .destAddE      (destAddE),
        .RegWriteE     (RegWriteE),
        .MemReadE      (MemReadE),
        .branchTakenE  (branchTakenE),
        .branchTargetE (branchTargetE),
        .memReq        (memReq),
        .memReady      (memReady),
        .stallF        (stallF),
        .stallD        (stallD),
        .stallE        (stallE),
        .stallM        (stallM),
        .bubbleE       (bubbleE),
        .flushD        (flushD),
        .pcSelF        (pcSelF),
        .pcTargetF     (pcTargetF)
`ifdef HAZARD_PERF_EN
        ,
        .stallCycles   (stallCycles),
        .redirectCount (redirectCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {stallF, stallD, stallE, stallM, bubbleE, flushD, pcSelF}
    function automatic logic [18:0] ov(input logic [6:0] ctl, input logic [11:0] tgt);
        return {ctl, tgt};
    endfunction

    function automatic logic [18:0] model_out();
        logic [18:0] e;
        bit mw;
        bit lu;
        e  = '0;
        mw = memReq && !memReady;
        lu = MemReadE && RegWriteE &&
             ((srcUseD1 && srcAddD1 == destAddE) || (srcUseD2 && srcAddD2 == destAddE));
        if (!reset) return '0;
        if (m_wait) begin
            if (!memReady) e[18:15] = 4'hF;
        end else if (m_flush > 0) begin
            e[13] = 1'b1;
            if (mw) e[18:15] = 4'hF;
        end else if (mw) begin
            e[18:15] = 4'hF;
        end else if (branchTakenE) begin
            e[14]   = 1'b1;
            e[13]   = 1'b1;
            e[12]   = 1'b1;
            e[11:0] = branchTargetE;
        end else if (lu) begin
            e[18] = 1'b1;
            e[17] = 1'b1;
            e[14] = 1'b1;
        end
        return e;
    endfunction

    task automatic model_reset();
        m_wait   = 1'b0;
        m_flush  = 0;
        m_stalls = 0;
        m_redirs = 0;
    endtask

    // One clock edge; the model advances using the inputs held across it.
    task automatic advance();
        logic [18:0] e;
        bit mw;
        @(posedge clk);
        e  = model_out();
        mw = memReq && !memReady;
        if (!reset) begin
            model_reset();
        end else begin
            if (e[18] && m_stalls < 65535) m_stalls++;
            if (e[12] && m_redirs < 65535) m_redirs++;
            if (m_wait) begin
                if (memReady) m_wait = 1'b0;
            end else if (m_flush > 0) begin
                if (!mw) m_flush--;
            end else if (mw) begin
                m_wait = 1'b1;
            end else if (branchTakenE) begin
                m_flush = FLUSH - 1;
            end
        end
        #1;
    endtask

    task automatic idle();
        srcAddD1 = 4'h0; srcAddD2 = 4'h0; srcUseD1 = 1'b0; srcUseD2 = 1'b0;
        destAddE = 4'h0; RegWriteE = 1'b0; MemReadE = 1'b0;
        branchTakenE = 1'b0; branchTargetE = 12'h000;
        memReq = 1'b0; memReady = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        branchTakenE = 1'b1; branchTargetE = 12'h7FF; memReq = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 19'h0);
        end
        advance();
        reset = 1'b1;
        idle();
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_release_idle: got %h expected %h", obs, 19'h0);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (stallCycles !== 16'd0 || redirectCount !== 16'd0) begin
            errors++;
            $display("FAIL perf_reset: got %h/%h expected 0/0", stallCycles, redirectCount);
        end
`endif
        advance();
    endtask

    task automatic test_load_use();
        logic [18:0] want;
        idle();
        MemReadE = 1'b1; RegWriteE = 1'b1; destAddE = 4'h3; srcAddD2 = 4'h3; srcUseD2 = 1'b1;
        @(negedge clk);
        want = ov(7'b1100100, 12'h0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL load_use_hit: got %h expected %h", obs, want);
        end
        advance();
        destAddE = 4'h5;
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL load_use_next: got %h expected %h", obs, 19'h0);
        end
        advance();
        destAddE = 4'h3; srcUseD2 = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL load_use_unused_src: got %h expected %h", obs, 19'h0);
        end
        advance();
        destAddE = 4'h0; srcAddD1 = 4'h0; srcUseD1 = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL load_use_reg0: got %h expected %h", obs, want);
        end
        advance();
        MemReadE = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL load_use_no_load: got %h expected %h", obs, 19'h0);
        end
        advance();
        idle();
    endtask

    task automatic test_branch();
        logic [18:0] want;
        idle();
        branchTakenE = 1'b1; branchTargetE = 12'h0A4;
        @(negedge clk);
        want = ov(7'b0000111, 12'h0A4);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL branch_cycle0: got %h expected %h", obs, want);
        end
        advance();
        // Branch and load-use presented during the flush must be ignored.
        branchTargetE = 12'h123;
        MemReadE = 1'b1; RegWriteE = 1'b1; destAddE = 4'h2; srcAddD1 = 4'h2; srcUseD1 = 1'b1;
        @(negedge clk);
        want = ov(7'b0000010, 12'h0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL branch_cycle1: got %h expected %h", obs, want);
        end
        advance();
        idle();
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL branch_cycle2: got %h expected %h", obs, 19'h0);
        end
        advance();
    endtask

    task automatic test_mem_wait();
        logic [18:0] want;
        idle();
        want = ov(7'b1111000, 12'h0);
        memReq = 1'b1; memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL mem_wait_cycle%0d: got %h expected %h", i, obs, want);
            end
            advance();
        end
        memReady = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL mem_wait_ready: got %h expected %h", obs, 19'h0);
        end
        advance();
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL mem_ready_same_cycle: got %h expected %h", obs, 19'h0);
        end
        advance();
        idle();
    endtask

    task automatic test_collision();
        logic [18:0] want;
        idle();
        memReq = 1'b1; memReady = 1'b0;
        branchTakenE = 1'b1; branchTargetE = 12'h3C5;
        MemReadE = 1'b1; RegWriteE = 1'b1; destAddE = 4'h9; srcAddD2 = 4'h9; srcUseD2 = 1'b1;
        @(negedge clk);
        want = ov(7'b1111000, 12'h0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL collision_stall: got %h expected %h", obs, want);
        end
        advance();
        memReady = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL collision_ready: got %h expected %h", obs, 19'h0);
        end
        advance();
        memReq = 1'b0; memReady = 1'b0;
        @(negedge clk);
        want = ov(7'b0000111, 12'h3C5);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL collision_redirect: got %h expected %h", obs, want);
        end
        advance();
        idle();
        @(negedge clk);
        want = ov(7'b0000010, 12'h0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL collision_flush: got %h expected %h", obs, want);
        end
        advance();
    endtask

    task automatic test_reset_redirect();
        idle();
        branchTakenE = 1'b1; branchTargetE = 12'h155;
        advance();
        branchTakenE = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== ov(7'b0000010, 12'h0)) begin
            errors++;
            $display("FAIL rst_pre_flush: got %h expected %h", obs, ov(7'b0000010, 12'h0));
        end
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL rst_async_outputs: got %h expected %h", obs, 19'h0);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if (stallCycles !== 16'd0 || redirectCount !== 16'd0) begin
            errors++;
            $display("FAIL rst_async_perf: got %h/%h expected 0/0", stallCycles, redirectCount);
        end
`endif
        advance();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL rst_after_release: got %h expected %h", obs, 19'h0);
        end
        advance();
    endtask

    task automatic test_random();
        logic [18:0] want;
        for (int n = 0; n < 400; n++) begin
            memReq        = ($urandom_range(0, 9) < 3);
            memReady      = 1'($urandom_range(0, 1));
            branchTakenE  = ($urandom_range(0, 9) < 2);
            branchTargetE = 12'($urandom);
            MemReadE      = 1'($urandom_range(0, 1));
            RegWriteE     = 1'($urandom_range(0, 1));
            destAddE      = 4'($urandom_range(0, 3));
            srcAddD1      = 4'($urandom_range(0, 3));
            srcAddD2      = 4'($urandom_range(0, 3));
            srcUseD1      = 1'($urandom_range(0, 1));
            srcUseD2      = 1'($urandom_range(0, 1));
            @(negedge clk);
            want = model_out();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", n, obs, want);
            end
`ifdef HAZARD_PERF_EN
            checks++;
            if (stallCycles !== 16'(m_stalls) || redirectCount !== 16'(m_redirs)) begin
                errors++;
                $display("FAIL random_perf%0d: got %0d/%0d expected %0d/%0d",
                         n, stallCycles, redirectCount, m_stalls, m_redirs);
            end
`endif
            advance();
        end
        idle();
        memReady = 1'b1;
        advance();
        advance();
        idle();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf_saturation();
        idle();
        memReq = 1'b1; memReady = 1'b0;
        for (int i = 0; i < 65540; i++) advance();
        @(negedge clk);
        checks++;
        if (stallCycles !== 16'hFFFF) begin
            errors++;
            $display("FAIL perf_stall_saturate: got %h expected %h", stallCycles, 16'hFFFF);
        end
        memReady = 1'b1;
        advance();
        idle();
        advance();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        idle();
        model_reset();
        #2;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_collision();
        test_reset_redirect();
        test_random();
`ifdef HAZARD_PERF_EN
        test_perf_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
